// File: rtl/vga_state_display.sv
// VGA timing generator and game-state colour selector for the display path.
// The game state is sampled once per frame so a screen never changes mid-frame.
//
// state_q  | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | black screen
// ST_PLAY  | renderer colour (CIN) passed through
// ST_WIN   | WIN_COLOUR blinking, BLINK_FRAMES frames per phase
// ST_LOSE  | solid LOSE_COLOUR
module vga_state_display #(
    parameter int                   COLOUR_W     = 8,
    parameter int                   H_ADDR_W     = 10,
    parameter int                   V_ADDR_W     = 10,
    parameter int                   H_ACTIVE     = 640,
    parameter int                   H_FP         = 16,
    parameter int                   H_SYNC       = 96,
    parameter int                   H_BP         = 48,
    parameter int                   V_ACTIVE     = 480,
    parameter int                   V_FP         = 10,
    parameter int                   V_SYNC       = 2,
    parameter int                   V_BP         = 33,
    parameter logic                 SYNC_POL     = 1'b0,
    parameter int                   PIX_DIV      = 2,
    parameter int                   BLINK_FRAMES = 30,
    parameter logic [COLOUR_W-1:0]  WIN_COLOUR   = 8'b00010000,
    parameter logic [COLOUR_W-1:0]  LOSE_COLOUR  = 8'b00000111
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [1:0]           MASTER_STATE,
    input  logic [COLOUR_W-1:0]  CIN,
    output logic [H_ADDR_W-1:0]  ADDRH,
    output logic [V_ADDR_W-1:0]  ADDRV,
    output logic                 PIX_EN,
    output logic                 HS,
    output logic                 VS,
    output logic                 DE,
    output logic                 FRAME_START,
    output logic [COLOUR_W-1:0]  COLOUR
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST     = DIV_W'(PIX_DIV - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST   = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [H_ADDR_W-1:0] H_LAST       = H_ADDR_W'(H_TOTAL - 1);
    localparam logic [H_ADDR_W-1:0] H_VIS_END    = H_ADDR_W'(H_ACTIVE);
    localparam logic [H_ADDR_W-1:0] H_SYNC_START = H_ADDR_W'(H_ACTIVE + H_FP);
    localparam logic [H_ADDR_W-1:0] H_SYNC_END   = H_ADDR_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_ADDR_W-1:0] V_LAST       = V_ADDR_W'(V_TOTAL - 1);
    localparam logic [V_ADDR_W-1:0] V_VIS_END    = V_ADDR_W'(V_ACTIVE);
    localparam logic [V_ADDR_W-1:0] V_SYNC_START = V_ADDR_W'(V_ACTIVE + V_FP);
    localparam logic [V_ADDR_W-1:0] V_SYNC_END   = V_ADDR_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } game_state_t;

    logic [DIV_W-1:0]    div_cnt;
    logic [H_ADDR_W-1:0] h_cnt;
    logic [V_ADDR_W-1:0] v_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_on;
    game_state_t         state_q;

    logic                h_last;
    logic                v_last;
    logic                frame_last;
    logic                vis;
    logic                h_sync_win;
    logic                v_sync_win;
    logic [COLOUR_W-1:0] mode_colour;

    assign ADDRH = h_cnt;
    assign ADDRV = v_cnt;

    // Pixel strobe: registered so PIX_EN is a clean one-CLK pulse.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            div_cnt <= '0;
            PIX_EN  <= 1'b0;
        end else begin
            PIX_EN <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        h_last     = (h_cnt == H_LAST);
        v_last     = (v_cnt == V_LAST);
        frame_last = h_last && v_last;
        vis        = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        h_sync_win = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
        v_sync_win = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (PIX_EN) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mode_colour = '0;
        case (state_q)
            ST_IDLE: mode_colour = '0;
            ST_PLAY: mode_colour = CIN;
            ST_WIN:  mode_colour = blink_on ? WIN_COLOUR : '0;
            ST_LOSE: mode_colour = LOSE_COLOUR;
            default: mode_colour = '0;
        endcase
    end

    // Output stage lags the counters by one pixel slot; CIN is sampled here.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            DE     <= 1'b0;
            HS     <= ~SYNC_POL;
            VS     <= ~SYNC_POL;
            COLOUR <= '0;
        end else if (PIX_EN) begin
            DE     <= vis;
            HS     <= h_sync_win ? SYNC_POL : ~SYNC_POL;
            VS     <= v_sync_win ? SYNC_POL : ~SYNC_POL;
            COLOUR <= vis ? mode_colour : '0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= 1'b0;
            if (PIX_EN && frame_last) begin
                FRAME_START <= 1'b1;
                state_q     <= game_state_t'(MASTER_STATE);
                if (game_state_t'(MASTER_STATE) != ST_WIN || state_q != ST_WIN) begin
                    // Entering (or outside) the win screen always starts lit.
                    blink_cnt <= '0;
                    blink_on  <= 1'b1;
                end else if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_state_display.sv
// Directed bench for vga_state_display using a shrunken 16x8-pixel raster
// (8x4 visible) so whole frames fit in a short run.
module tb_vga_state_display;

    logic       CLK;
    logic       RESETN;
    logic [1:0] MASTER_STATE;
    logic [7:0] CIN;
    logic [9:0] ADDRH;
    logic [9:0] ADDRV;
    logic       PIX_EN;
    logic       HS;
    logic       VS;
    logic       DE;
    logic       FRAME_START;
    logic [7:0] COLOUR;

    int vectors;
    int miscompares;

    vga_state_display #(
        .COLOUR_W(8), .H_ADDR_W(10), .V_ADDR_W(10),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIX_DIV(2), .BLINK_FRAMES(2),
        .WIN_COLOUR(8'h10), .LOSE_COLOUR(8'h07)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .MASTER_STATE(MASTER_STATE),
        .CIN(CIN),
        .ADDRH(ADDRH),
        .ADDRV(ADDRV),
        .PIX_EN(PIX_EN),
        .HS(HS),
        .VS(VS),
        .DE(DE),
        .FRAME_START(FRAME_START),
        .COLOUR(COLOUR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Park at the negedge where the next posedge processes pixel (h,v).
    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(PIX_EN === 1'b1 && ADDRH == 10'(h) && ADDRV == 10'(v)) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            miscompares++;
            $error("FAIL wait_pos(%0d,%0d): timed out at ADDRH=%0d ADDRV=%0d", h, v, ADDRH, ADDRV);
        end
    endtask

    // Drive CIN for pixel (h,v) and return at the negedge after it is processed.
    task automatic pixel(input int h, input int v, input logic [7:0] cin_val);
        wait_pos(h, v);
        CIN = cin_val;
        @(posedge CLK);
        @(negedge CLK);
        CIN = 8'h00;
    endtask

    task automatic release_and_check(input string pfx);
        @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
        check({pfx, "_pix_en_clk1"}, PIX_EN, 0);
        @(negedge CLK);
        check({pfx, "_pix_en_clk2"}, PIX_EN, 1);
        check({pfx, "_addrh_0"}, ADDRH, 0);
        @(negedge CLK);
        check({pfx, "_addrh_1"}, ADDRH, 1);
        @(negedge CLK);
        @(negedge CLK);
        check({pfx, "_addrh_2"}, ADDRH, 2);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_pix_en"}, PIX_EN, 0);
        check({pfx, "_de"}, DE, 0);
        check({pfx, "_hs"}, HS, 1);
        check({pfx, "_vs"}, VS, 1);
        check({pfx, "_colour"}, COLOUR, 0);
        check({pfx, "_frame_start"}, FRAME_START, 0);
        check({pfx, "_addrh"}, ADDRH, 0);
        check({pfx, "_addrv"}, ADDRV, 0);
    endtask

    logic [1:0] blink_ms  [8];
    logic [7:0] blink_exp [8];

    initial begin
        int n;
        int hs_low;
        int de_high;
        int vs_low;

        vectors      = 0;
        miscompares  = 0;
        RESETN       = 1'b0;
        MASTER_STATE = 2'd0;
        CIN          = 8'h00;

        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        release_and_check("por");

        // Frame latch pulse and frame period (16*8 pixels * 2 CLK = 256).
        MASTER_STATE = 2'd1;
        wait_pos(15, 7);
        @(negedge CLK);
        check("frame_start_pulse", FRAME_START, 1);
        @(negedge CLK);
        check("frame_start_width", FRAME_START, 0);
        n = 1;
        while (FRAME_START !== 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("frame_period_clks", n, 256);

        vs_low = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            if (VS === 1'b0) vs_low++;
        end
        check("vs_low_clks", vs_low, 64);

        // One full visible line: HS low 3 pixels, DE high 8 pixels.
        wait_pos(0, 1);
        hs_low  = 0;
        de_high = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            if (HS === 1'b0) hs_low++;
            if (DE === 1'b1) de_high++;
        end
        check("hs_low_clks", hs_low, 6);
        check("de_high_clks", de_high, 16);

        pixel(3, 2, 8'hA5);
        check("pass_colour", COLOUR, 8'hA5);
        check("pass_de", DE, 1);
        pixel(7, 2, 8'h3C);
        check("pass_last_active", COLOUR, 8'h3C);
        pixel(9, 2, 8'hFF);
        check("hblank_colour", COLOUR, 0);
        check("hblank_de", DE, 0);
        check("hs_before_sync", HS, 1);
        pixel(10, 2, 8'hFF);
        check("hs_sync_start", HS, 0);
        pixel(13, 2, 8'hFF);
        check("hs_sync_end", HS, 1);
        pixel(3, 4, 8'hFF);
        check("vblank_colour", COLOUR, 0);
        check("vblank_de", DE, 0);

        // Mid-frame state change is held off until the frame boundary.
        wait_pos(0, 2);
        MASTER_STATE = 2'd3;
        pixel(5, 3, 8'h5A);
        check("latch_hold_colour", COLOUR, 8'h5A);
        pixel(5, 0, 8'h5A);
        check("lose_colour_a", COLOUR, 8'h07);
        pixel(0, 3, 8'h5A);
        check("lose_colour_b", COLOUR, 8'h07);
        pixel(9, 1, 8'h5A);
        check("lose_blank", COLOUR, 0);

        // Blink: idle, win x3, idle, win x3 (BLINK_FRAMES=2).
        blink_ms  = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2};
        blink_exp = '{8'h00, 8'h10, 8'h10, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) begin
            MASTER_STATE = blink_ms[i];
            wait_pos(0, 5);
            pixel(2, 1, 8'h77);
            check($sformatf("blink_frame%0d", i), COLOUR, blink_exp[i]);
        end

        // Asynchronous reset in the middle of a visible line.
        MASTER_STATE = 2'd1;
        wait_pos(0, 5);
        wait_pos(6, 2);
        CIN = 8'hC3;
        @(posedge CLK);
        #2;
        check("pre_reset_colour", COLOUR, 8'hC3);
        RESETN = 1'b0;
        #1;
        check_reset_outputs("async");
        CIN = 8'h00;
        release_and_check("rel");
        pixel(3, 1, 8'hFF);
        check("state_cleared_by_reset", COLOUR, 0);
        pixel(3, 1, 8'hFF);
        check("state_relatched", COLOUR, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_state_display.md
Name: vga_state_display

Overview:
- Parametrised VGA timing and colour-select stage for the game display.
- Generates its own pixel-enable strobe, H/V counters, sync and data-enable signals.
- Outputs pixel addresses to the frame/board renderer and muxes the returned colour against game-state screens: black, playing, blinking win, and lose.
- The game-state input is latched once per frame to prevent mid-frame tearing.
- Sits between the game FSM/board renderer and the VGA connector.

Parameters:
- COLOUR_W, 8: width of CIN/COLOUR.
- H_ADDR_W, 10: width of ADDRH.
- V_ADDR_W, 10: width of ADDRV.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch (pixels).
- H_SYNC, 96: horizontal sync width (pixels).
- H_BP, 48: horizontal back porch (pixels).
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch (lines).
- V_SYNC, 2: vertical sync width (lines).
- V_BP, 33: vertical back porch (lines).
- SYNC_POL, 0: asserted level of HS/VS.
- PIX_DIV, 2: CLK cycles per pixel (≥1).
- BLINK_FRAMES, 30: frames per blink phase in the win state (≥1).
- WIN_COLOUR, 8'b00010000: win screen colour.
- LOSE_COLOUR, 8'b00000111: lose screen colour.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous, active-low reset.
- MASTER_STATE  in  2  game state: 0 idle, 1 playing, 2 win, 3 lose.
- CIN  in  COLOUR_W  renderer colour for current ADDRH/ADDRV.
- ADDRH  out  H_ADDR_W  horizontal counter value.
- ADDRV  out  V_ADDR_W  vertical counter value.
- PIX_EN  out  1  one-CLK pixel strobe.
- HS  out  1  horizontal sync.
- VS  out  1  vertical sync.
- DE  out  1  active-video flag, aligned with COLOUR.
- FRAME_START  out  1  one-CLK pulse per frame.
- COLOUR  out  COLOUR_W  pixel colour to DAC.

Behaviour:
- Divider:
  - div_cnt counts 0..PIX_DIV-1; PIX_EN is registered high for the one CLK after div_cnt reaches PIX_DIV-1.
  - With PIX_DIV=1, PIX_EN is constant 1 from the first clock after reset release.
- Counters advance only on CLK edges where PIX_EN=1.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; h_cnt wraps H_TOTAL-1 → 0.
  - On that wrap, v_cnt increments; V_TOTAL is defined likewise, and v_cnt wraps V_TOTAL-1 → 0.
  - ADDRH = h_cnt and ADDRV = v_cnt, driven directly from the counter registers.
- Output stage (one pixel slot of latency) updates on PIX_EN edges from the pre-increment counter values:
  - DE <= (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - HS <= SYNC_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
  - VS <= SYNC_POL when v_cnt is in the analogous vertical window, else ~SYNC_POL.
  - COLOUR <= 0 if not DE-qualified; otherwise the mode colour.
  - CIN is sampled on that same edge, so renderer latency must be ≤ PIX_DIV-1 CLKs.
- Frame latch:
  - At the PIX_EN edge where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, state_q <= MASTER_STATE.
  - FRAME_START is high for exactly the following CLK.
  - MASTER_STATE changes mid-frame have no effect until the next frame.
- Mode colour from state_q:
  - 0: all zeros.
  - 1: CIN.
  - 2: WIN_COLOUR when blink_on=1, else zeros.
  - 3: LOSE_COLOUR.
- Blink logic:
  - blink_cnt counts frames 0..BLINK_FRAMES-1 at each frame latch; on reaching BLINK_FRAMES-1 it wraps and toggles blink_on.
  - When the latch loads state 2 from any other state, blink_cnt=0 and blink_on=1.
  - Outside state 2, blink_cnt=0 and blink_on=1.
- Reset (asynchronous, any time, including mid-line):
  - Registers: div_cnt=0, h_cnt=0, v_cnt=0, state_q=0, blink_cnt=0, blink_on=1.
  - Outputs: PIX_EN=0, DE=0, HS=~SYNC_POL, VS=~SYNC_POL, COLOUR=0, FRAME_START=0, ADDRH=0, ADDRV=0.
  - Timing restarts from pixel (0,0) after release.
- MASTER_STATE is assumed synchronous to CLK. There are no other inputs.

Test Plan:
- Reset: assert RESETN=0 mid-line (h_cnt=300) → all outputs go to reset values immediately; after release, the first PIX_EN arrives 2 CLKs later and ADDRH steps 0,1,2.
- Horizontal timing (defaults): measure HS → low for 192 CLKs; line period 1600 CLKs; DE high for 1280 CLKs per visible line.
- Vertical timing: VS low for 2 lines (3200 CLKs); frame = 525 lines; FRAME_START pulses once every 840000 CLKs.
- Pass-through: state 1; renderer returns CIN=8'hA5 when ADDRH=10 and ADDRV=10 → COLOUR=8'hA5 in the pixel slot after the one showing ADDRH=10. With CIN=8'hFF at ADDRH=700 → COLOUR=0.
- Frame latch: switch MASTER_STATE 1 → 3 at v_cnt=200 → COLOUR keeps following CIN until the frame ends, then equals 8'h07 on every active pixel.
- Blink: BLINK_FRAMES=2, MASTER_STATE=2 from idle → frames show 8'h10, 8'h10, 0, 0, 8'h10, …; switching to 0 and back to 2 restarts with an on phase.
